// File: rtl/axil_port_arbiter.sv
// axil_port_arbiter
//
// Shares one AXI4-Lite master port between NUM_REQ requesters using
// round-robin arbitration. Only one transaction is in flight at a time.
// The block runs the AR/R or AW/W/B handshakes for the winner, then returns
// the read data or write status to that requester with a one-cycle done pulse.
//
// Ports
//   i_Clock, i_Reset_N          clock (rising edge), synchronous active-low reset
//   i_Req/i_Write               per-requester request and direction (1 = write)
//   i_Addr/i_Wdata/i_Wstrb      packed per-requester fields, slot k at [k*W +: W]
//   o_Grant                     one-hot owner of the current transaction
//   o_Done/o_Err                completion pulse to the owner, error flag with it
//   o_Rdata                     last read data; holds until the next read completes
//   m_axil_*                    AXI4-Lite master port (AR, R, AW, W, B channels)
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | no owner; pick a winner from the pointer upward with wrap
//   RD_ADDR  | arvalid asserted with the latched address
//   RD_DATA  | rready asserted, waiting for rvalid
//   WR_REQ   | awvalid/wvalid asserted, each dropping after its handshake
//   WR_RESP  | bready asserted, waiting for bvalid
//   COMPLETE | done pulse to the owner, pointer advances past the owner

module axil_port_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int XLEN      = 32,
    parameter int PTR_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_N,

    input  logic [NUM_REQ-1:0]          i_Req,
    input  logic [NUM_REQ-1:0]          i_Write,
    input  logic [NUM_REQ*XLEN-1:0]     i_Addr,
    input  logic [NUM_REQ*XLEN-1:0]     i_Wdata,
    input  logic [NUM_REQ*XLEN/8-1:0]   i_Wstrb,

    output logic [NUM_REQ-1:0]          o_Grant,
    output logic [NUM_REQ-1:0]          o_Done,
    output logic [XLEN-1:0]             o_Rdata,
    output logic                        o_Err,

    output logic [XLEN-1:0]             m_axil_araddr,
    output logic                        m_axil_arvalid,
    input  logic                        m_axil_arready,

    input  logic [XLEN-1:0]             m_axil_rdata,
    input  logic [1:0]                  m_axil_rresp,
    input  logic                        m_axil_rvalid,
    output logic                        m_axil_rready,

    output logic [XLEN-1:0]             m_axil_awaddr,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,

    output logic [XLEN-1:0]             m_axil_wdata,
    output logic [XLEN/8-1:0]           m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,

    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready
);

    localparam int SW = XLEN / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ADDR  = 3'd1,
        RD_DATA  = 3'd2,
        WR_REQ   = 3'd3,
        WR_RESP  = 3'd4,
        COMPLETE = 3'd5
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [PTR_WIDTH-1:0]   ptr;
    logic [PTR_WIDTH-1:0]   owner;
    logic [PTR_WIDTH-1:0]   winner;
    logic [PTR_WIDTH:0]     scan_idx;
    logic                   any_req;

    logic [XLEN-1:0]        addr_q;
    logic [XLEN-1:0]        wdata_q;
    logic [SW-1:0]          wstrb_q;
    logic                   err_q;
    logic                   aw_done;
    logic                   w_done;

    // Round-robin pick: scan NUM_REQ slots starting at the pointer. The scan
    // index is one bit wider than the pointer so ptr+i cannot overflow
    // before the wrap subtraction.
    always_comb begin
        winner   = '0;
        any_req  = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, ptr} + (PTR_WIDTH+1)'(i);
            if (scan_idx >= (PTR_WIDTH+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_WIDTH+1)'(NUM_REQ);
            end
            if (!any_req && i_Req[scan_idx[PTR_WIDTH-1:0]]) begin
                any_req = 1'b1;
                winner  = scan_idx[PTR_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = i_Write[winner] ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                m_axil_arvalid = 1'b1;
                if (m_axil_arready) begin
                    state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                m_axil_rready = 1'b1;
                if (m_axil_rvalid) begin
                    state_nxt = COMPLETE;
                end
            end
            WR_REQ: begin
                m_axil_awvalid = !aw_done;
                m_axil_wvalid  = !w_done;
                // A channel counts as finished if it already handshook or
                // handshakes this cycle, so AW and W may land in any order.
                if ((aw_done || m_axil_awready) && (w_done || m_axil_wready)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                m_axil_bready = 1'b1;
                if (m_axil_bvalid) begin
                    state_nxt = COMPLETE;
                end
            end
            COMPLETE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            ptr     <= '0;
            owner   <= '0;
            o_Grant <= '0;
            o_Rdata <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            err_q   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        o_Grant <= NUM_REQ'(1) << winner;
                        owner   <= winner;
                        addr_q  <= i_Addr[int'(winner)*XLEN +: XLEN];
                        wdata_q <= i_Wdata[int'(winner)*XLEN +: XLEN];
                        wstrb_q <= i_Wstrb[int'(winner)*SW +: SW];
                        err_q   <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (m_axil_rvalid) begin
                        o_Rdata <= m_axil_rdata;
                        err_q   <= |m_axil_rresp;
                    end
                end
                WR_REQ: begin
                    if (m_axil_awvalid && m_axil_awready) begin
                        aw_done <= 1'b1;
                    end
                    if (m_axil_wvalid && m_axil_wready) begin
                        w_done <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        err_q <= |m_axil_bresp;
                    end
                end
                COMPLETE: begin
                    o_Grant <= '0;
                    if (owner == PTR_WIDTH'(NUM_REQ - 1)) begin
                        ptr <= '0;
                    end else begin
                        ptr <= owner + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // o_Grant still names the owner during COMPLETE, so it doubles as the
    // done vector for that cycle.
    assign o_Done = (state == COMPLETE) ? o_Grant : '0;
    assign o_Err  = (state == COMPLETE) && err_q;

    assign m_axil_araddr = addr_q;
    assign m_axil_awaddr = addr_q;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;

endmodule

// File: tb/tb_axil_port_arbiter.sv
// Testbench for axil_port_arbiter (NUM_REQ=2, XLEN=32).
// Single-requester transactions come from a vector table with hand-computed
// expectations; contention, reset mid-read and early request drop are
// hand-written sequences.

module tb_axil_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int XLEN    = 32;

    logic                      i_Clock;
    logic                      i_Reset_N;
    logic [NUM_REQ-1:0]        i_Req;
    logic [NUM_REQ-1:0]        i_Write;
    logic [NUM_REQ*XLEN-1:0]   i_Addr;
    logic [NUM_REQ*XLEN-1:0]   i_Wdata;
    logic [NUM_REQ*XLEN/8-1:0] i_Wstrb;
    logic [NUM_REQ-1:0]        o_Grant;
    logic [NUM_REQ-1:0]        o_Done;
    logic [XLEN-1:0]           o_Rdata;
    logic                      o_Err;
    logic [XLEN-1:0]           m_axil_araddr;
    logic                      m_axil_arvalid;
    logic                      m_axil_arready;
    logic [XLEN-1:0]           m_axil_rdata;
    logic [1:0]                m_axil_rresp;
    logic                      m_axil_rvalid;
    logic                      m_axil_rready;
    logic [XLEN-1:0]           m_axil_awaddr;
    logic                      m_axil_awvalid;
    logic                      m_axil_awready;
    logic [XLEN-1:0]           m_axil_wdata;
    logic [XLEN/8-1:0]         m_axil_wstrb;
    logic                      m_axil_wvalid;
    logic                      m_axil_wready;
    logic [1:0]                m_axil_bresp;
    logic                      m_axil_bvalid;
    logic                      m_axil_bready;

    axil_port_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
        .i_Clock        (i_Clock),
        .i_Reset_N      (i_Reset_N),
        .i_Req          (i_Req),
        .i_Write        (i_Write),
        .i_Addr         (i_Addr),
        .i_Wdata        (i_Wdata),
        .i_Wstrb        (i_Wstrb),
        .o_Grant        (o_Grant),
        .o_Done         (o_Done),
        .o_Rdata        (o_Rdata),
        .o_Err          (o_Err),
        .m_axil_araddr  (m_axil_araddr),
        .m_axil_arvalid (m_axil_arvalid),
        .m_axil_arready (m_axil_arready),
        .m_axil_rdata   (m_axil_rdata),
        .m_axil_rresp   (m_axil_rresp),
        .m_axil_rvalid  (m_axil_rvalid),
        .m_axil_rready  (m_axil_rready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    typedef struct {
        int          k;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          a_wait;     // cycles before arready / awready
        int          w_wait;     // cycles before wready (writes only)
        int          d_wait;     // cycles before rvalid / bvalid
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];
    int   checks;
    int   errors;
    bit   mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; also checks
    // the grant/valid invariants every cycle once enabled.
    task automatic tick();
        @(posedge i_Clock);
        #1;
        if (mon_en) begin
            checks++;
            if (!$onehot0(o_Grant) || (m_axil_arvalid && m_axil_awvalid)) begin
                errors++;
                $display("FAIL invariant grant=%b arvalid=%b awvalid=%b",
                         o_Grant, m_axil_arvalid, m_axil_awvalid);
            end
        end
    endtask

    task automatic set_req(input int k, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        i_Addr  = {~addr, ~addr};
        i_Wdata = {~wdata, ~wdata};
        i_Wstrb = {~wstrb, ~wstrb};
        i_Addr[k*32 +: 32] = addr;
        i_Wdata[k*32 +: 32] = wdata;
        i_Wstrb[k*4 +: 4] = wstrb;
        i_Write[k] = wr;
        i_Req[k] = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        set_req(v.k, v.wr, v.addr, v.wdata, v.wstrb);
        tick();
        chk("grant", 32'(o_Grant), 32'(1) << v.k);
        if (!v.wr) begin
            for (int c = 0; c <= v.a_wait; c++) begin
                m_axil_arready = (c == v.a_wait);
                chk("arvalid", 32'(m_axil_arvalid), 32'd1);
                chk("araddr", m_axil_araddr, v.addr);
                chk("rready_early", 32'(m_axil_rready), 32'd0);
                chk("awvalid_in_read", 32'(m_axil_awvalid), 32'd0);
                tick();
            end
            m_axil_arready = 1'b0;
            for (int c = 0; c <= v.d_wait; c++) begin
                m_axil_rvalid = (c == v.d_wait);
                m_axil_rdata  = v.rdata;
                m_axil_rresp  = v.resp;
                chk("rready", 32'(m_axil_rready), 32'd1);
                chk("arvalid_dropped", 32'(m_axil_arvalid), 32'd0);
                tick();
            end
            m_axil_rvalid = 1'b0;
        end else begin
            n = (v.a_wait > v.w_wait) ? v.a_wait : v.w_wait;
            for (int c = 0; c <= n; c++) begin
                m_axil_awready = (c == v.a_wait);
                m_axil_wready  = (c == v.w_wait);
                chk("awvalid", 32'(m_axil_awvalid), 32'(c <= v.a_wait));
                chk("wvalid", 32'(m_axil_wvalid), 32'(c <= v.w_wait));
                chk("bready_early", 32'(m_axil_bready), 32'd0);
                if (c <= v.a_wait) chk("awaddr", m_axil_awaddr, v.addr);
                if (c <= v.w_wait) begin
                    chk("wdata", m_axil_wdata, v.wdata);
                    chk("wstrb", 32'(m_axil_wstrb), 32'(v.wstrb));
                end
                tick();
            end
            m_axil_awready = 1'b0;
            m_axil_wready  = 1'b0;
            for (int c = 0; c <= v.d_wait; c++) begin
                m_axil_bvalid = (c == v.d_wait);
                m_axil_bresp  = v.resp;
                chk("bready", 32'(m_axil_bready), 32'd1);
                chk("aw_w_dropped", 32'({m_axil_awvalid, m_axil_wvalid}), 32'd0);
                tick();
            end
            m_axil_bvalid = 1'b0;
        end
        chk("done", 32'(o_Done), 32'(1) << v.k);
        chk("rdata", o_Rdata, v.exp_rdata);
        chk("err", 32'(o_Err), 32'(v.exp_err));
        i_Req = '0;
        tick();
        chk("done_pulse_end", 32'(o_Done), 32'd0);
        chk("grant_cleared", 32'(o_Grant), 32'd0);
    endtask

    int   ndone;
    int   owners[4];
    int   dcyc[4];
    vec_t sv;

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;

        vecs[0] = '{k:0, wr:1'b0, addr:32'h100, wdata:32'h0, wstrb:4'h0, a_wait:0, w_wait:0,
                    d_wait:2, rdata:32'hDEADBEEF, resp:2'b00, exp_rdata:32'hDEADBEEF, exp_err:1'b0};
        vecs[1] = '{k:1, wr:1'b1, addr:32'h200, wdata:32'h12345678, wstrb:4'hF, a_wait:3, w_wait:1,
                    d_wait:0, rdata:32'h0, resp:2'b00, exp_rdata:32'hDEADBEEF, exp_err:1'b0};
        vecs[2] = '{k:0, wr:1'b1, addr:32'h300, wdata:32'h0000A5A5, wstrb:4'h3, a_wait:0, w_wait:0,
                    d_wait:1, rdata:32'h0, resp:2'b10, exp_rdata:32'hDEADBEEF, exp_err:1'b1};
        vecs[3] = '{k:1, wr:1'b0, addr:32'h400, wdata:32'h0, wstrb:4'h0, a_wait:1, w_wait:0,
                    d_wait:0, rdata:32'hCAFEF00D, resp:2'b00, exp_rdata:32'hCAFEF00D, exp_err:1'b0};
        vecs[4] = '{k:1, wr:1'b0, addr:32'h404, wdata:32'h0, wstrb:4'h0, a_wait:0, w_wait:0,
                    d_wait:1, rdata:32'h00000011, resp:2'b11, exp_rdata:32'h00000011, exp_err:1'b1};
        vecs[5] = '{k:0, wr:1'b1, addr:32'h500, wdata:32'hFFFF0000, wstrb:4'hC, a_wait:0, w_wait:2,
                    d_wait:0, rdata:32'h0, resp:2'b00, exp_rdata:32'h00000011, exp_err:1'b0};

        i_Reset_N = 1'b0;
        i_Req = '0; i_Write = '0; i_Addr = '0; i_Wdata = '0; i_Wstrb = '0;
        m_axil_arready = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0; m_axil_rvalid = 1'b0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bresp = '0; m_axil_bvalid = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        chk("rst_grant", 32'(o_Grant), 32'd0);
        chk("rst_done", 32'(o_Done), 32'd0);
        chk("rst_err", 32'(o_Err), 32'd0);
        chk("rst_rdata", o_Rdata, 32'd0);
        chk("rst_valids", 32'({m_axil_arvalid, m_axil_awvalid, m_axil_wvalid}), 32'd0);
        chk("rst_readys", 32'({m_axil_rready, m_axil_bready}), 32'd0);
        i_Reset_N = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Contention from pointer 0 with a zero-wait slave: grants alternate
        // and a new transaction completes every 4 cycles.
        i_Reset_N = 1'b0;
        tick();
        i_Reset_N = 1'b1;
        m_axil_arready = 1'b1;
        m_axil_rvalid  = 1'b1;
        m_axil_rresp   = 2'b00;
        m_axil_rdata   = 32'h5A5A0001;
        i_Addr  = {32'h1000, 32'h0800};
        i_Write = '0;
        i_Req   = 2'b11;
        ndone = 0;
        for (int c = 1; c <= 40 && ndone < 4; c++) begin
            tick();
            if (o_Done != '0) begin
                owners[ndone] = (o_Done == 2'b01) ? 0 : (o_Done == 2'b10) ? 1 : 9;
                dcyc[ndone] = c;
                ndone++;
                if (ndone == 4) i_Req = '0;
            end
        end
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b0;
        chk("contention_count", 32'(ndone), 32'd4);
        chk("contention_first_lat", 32'(dcyc[0]), 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("contention_owner", 32'(owners[i]), 32'(i % 2));
            if (i > 0) chk("contention_period", 32'(dcyc[i] - dcyc[i-1]), 32'd4);
        end
        chk("contention_rdata", o_Rdata, 32'h5A5A0001);
        tick();

        // One read by requester 0 moves the pointer to 1.
        sv = '{k:0, wr:1'b0, addr:32'h604, wdata:32'h0, wstrb:4'h0, a_wait:0, w_wait:0,
               d_wait:0, rdata:32'h00000077, resp:2'b00, exp_rdata:32'h00000077, exp_err:1'b0};
        run_vec(sv);

        // Reset while in RD_DATA; afterwards requester 0 must win from pointer 0.
        set_req(0, 1'b0, 32'h600, 32'h0, 4'h0);
        tick();
        m_axil_arready = 1'b1;
        tick();
        m_axil_arready = 1'b0;
        chk("midrd_rready", 32'(m_axil_rready), 32'd1);
        i_Reset_N = 1'b0;
        tick();
        chk("midrd_grant", 32'(o_Grant), 32'd0);
        chk("midrd_rready_clr", 32'(m_axil_rready), 32'd0);
        chk("midrd_rdata_clr", o_Rdata, 32'd0);
        chk("midrd_done", 32'({o_Done, o_Err}), 32'd0);
        i_Reset_N = 1'b1;
        i_Addr  = {32'h0000BBBB, 32'h0000AAAA};
        i_Write = '0;
        i_Req   = 2'b11;
        tick();
        chk("postrst_grant", 32'(o_Grant), 32'd1);
        chk("postrst_araddr", m_axil_araddr, 32'h0000AAAA);
        m_axil_arready = 1'b1;
        tick();
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b1;
        m_axil_rdata   = 32'h00000099;
        tick();
        m_axil_rvalid = 1'b0;
        chk("postrst_done", 32'(o_Done), 32'd1);
        i_Req = '0;
        tick();

        // Early drop: requester 0 lets go of i_Req one cycle after grant.
        set_req(0, 1'b0, 32'h700, 32'h0, 4'h0);
        tick();
        chk("drop_grant", 32'(o_Grant), 32'd1);
        tick();
        i_Req = '0;
        m_axil_arready = 1'b1;
        tick();
        m_axil_arready = 1'b0;
        m_axil_rvalid  = 1'b1;
        m_axil_rdata   = 32'h00000088;
        tick();
        m_axil_rvalid = 1'b0;
        chk("drop_done", 32'(o_Done), 32'd1);
        chk("drop_rdata", o_Rdata, 32'h00000088);
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("drop_no_regrant", 32'({o_Grant, o_Done, m_axil_arvalid}), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_port_arbiter.md
Name: axil_port_arbiter

Overview:
- Round-robin arbiter that shares one AXI4-Lite master port between NUM_REQ requesters. Typical requesters are the core's stage-2 memory path and the debug peripheral (memory peek/poke).
- Sits between the requesters and the data-memory AXI-Lite interconnect.
- Exactly one transaction is outstanding at a time. The block sequences the AR/R or AW/W/B handshakes and returns the read data or write status to the granted requester.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
XLEN, 32, address/data width
PTR_WIDTH, $clog2(NUM_REQ), round-robin pointer width

Ports:
i_Clock  in  1  clock; all logic on rising edge
i_Reset_N  in  1  synchronous active-low reset
i_Req  in  NUM_REQ  per-requester request; held until matching o_Done
i_Write  in  NUM_REQ  per-requester 1=write, 0=read
i_Addr  in  NUM_REQ*XLEN  packed addresses, requester k at [k*XLEN +: XLEN]
i_Wdata  in  NUM_REQ*XLEN  packed write data
i_Wstrb  in  NUM_REQ*XLEN/8  packed write strobes
o_Grant  out  NUM_REQ  one-hot; owner of the current transaction
o_Done  out  NUM_REQ  one-cycle completion pulse to the owner
o_Rdata  out  XLEN  read data; valid in the o_Done cycle of a read
o_Err  out  1  pulses with o_Done when rresp/bresp != OKAY
m_axil_araddr/arvalid out, arready in  XLEN/1/1  AR channel
m_axil_rdata/rresp/rvalid in, rready out  XLEN/2/1/1  R channel
m_axil_awaddr/awvalid out, awready in  XLEN/1/1  AW channel
m_axil_wdata/wstrb/wvalid out, wready in  XLEN/XLEN/8/1/1  W channel
m_axil_bresp/bvalid in, bready out  2/1/1  B channel

Behaviour:
- Reset (i_Reset_N=0 at clock edge):
  - FSM to IDLE and pointer to 0.
  - o_Grant, o_Done, o_Err, o_Rdata, and all *valid/*ready outputs go to 0.
  - Reset mid-transaction abandons the transaction. The slave must be reset together with the arbiter.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, COMPLETE.
- IDLE:
  - If any i_Req is set, select the first set bit searching from the pointer upward with wrap.
  - Register o_Grant, the address, data, strobe and direction of the winner.
  - Go to RD_ADDR (read) or WR_REQ (write) on the next edge.
  - Request-to-arvalid/awvalid latency is exactly 1 cycle.
- RD_ADDR:
  - arvalid=1 with the latched address.
  - On arvalid&arready, drop arvalid and go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, latch rdata into o_Rdata, record rresp!=0, and go to COMPLETE.
- WR_REQ:
  - awvalid and wvalid both asserted. Each drops independently after its own handshake, tracked with aw_done and w_done flags.
  - AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, record bresp!=0 and go to COMPLETE.
- COMPLETE (1 cycle):
  - o_Done[owner]=1 and o_Err=recorded error.
  - o_Grant clears at the next edge.
  - Pointer becomes owner+1, wrapping to 0 at NUM_REQ.
  - Go to IDLE.
- Throughput: minimum 4 cycles per read and 4 per write with zero-wait slaves. A new grant can be issued in the cycle after COMPLETE.
- Requester rules:
  - Fields must be stable while i_Req=1.
  - Deasserting i_Req after grant does not cancel the transaction; it completes and o_Done still pulses.
  - A requester holding i_Req across its o_Done is treated as a new request.
- Addresses and data pass through unmodified. The arbiter does no alignment or width conversion.
- o_Rdata holds its last value until the next read completes. It is not cleared by writes.
- Invariants:
  - o_Grant is zero or one-hot at all times.
  - No *valid is asserted outside its state.
  - arvalid and awvalid are never both 1.

Test Plan:
- Single read: req0 read addr 0x100, slave arready same cycle, rdata 0xDEADBEEF after 2 wait cycles -> arvalid 1 cycle after req; o_Done[0] pulses once; o_Rdata=0xDEADBEEF; o_Err=0.
- Write with W before AW: req1 write 0x200, data 0x12345678, strb 0xF; wready cycle 1, awready cycle 3 -> wvalid drops after cycle 1 and awvalid after cycle 3; bready only afterwards; o_Done[1] pulses.
- Contention: req0 and req1 held continuously, all reads -> grants alternate 0,1,0,1 over 4 transactions; o_Grant always one-hot.
- Error: write with bresp=2'b10 -> o_Err=1 in the o_Done cycle; next OKAY read gives o_Err=0.
- Reset mid-read: assert i_Reset_N=0 while in RD_DATA -> next edge clears all outputs; the next request after release is granted from pointer 0.
- Early drop: req0 read, deassert i_Req[0] one cycle after grant -> transaction completes; o_Done[0] pulses; no second grant to requester 0.
